mem_stage_lsu: RTL and testbench

//  MEM-stage load/store unit, directly downstream of the EX/MEM pipeline register.

---
 rtl/mem_stage_lsu.sv | 166 ++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit driving a req/ack data-memory port.
// Optional misalignment trap: define LSU_MISALIGN_TRAP_EN.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_alu_data_m,
  input  logic [31:0] i_rs2_data_m,
  input  logic [31:0] i_instrM,
  input  logic        i_mem_wren_m,
  input  logic        i_wb_sel_m,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_bmask,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic [31:0] o_ld_data,
  output logic        o_stall_m,
  output logic        o_bus_err,
  output logic        o_misalign
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [31:0]      ld_q, ld_d;

  logic [2:0]  funct3;
  logic        is_store, is_load, access, misaligned, go;
  logic [3:0]  bmask_st;
  logic [31:0] wdata_st, ld_ext, ld_out;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        req, stall, bus_err;
  logic        unused_instr;

  assign funct3       = i_instrM[14:12];
  assign unused_instr = ^{i_instrM[31:15], i_instrM[11:0]};
  assign is_store     = i_mem_wren_m;
  assign is_load      = i_wb_sel_m & ~i_mem_wren_m;
  assign access       = i_mem_wren_m | i_wb_sel_m;

`ifdef LSU_MISALIGN_TRAP_EN
  logic half_acc, word_acc;
  assign half_acc   = is_store ? (funct3 == 3'b001) : (funct3 == 3'b001 || funct3 == 3'b101);
  assign word_acc   = (funct3 == 3'b010);
  assign misaligned = access & ((half_acc & i_alu_data_m[0]) | (word_acc & (|i_alu_data_m[1:0])));
  assign o_misalign = i_rst & (state_q == IDLE) & misaligned;
`else
  assign misaligned = 1'b0;
  assign o_misalign = 1'b0;
`endif

  assign go = access & ~misaligned;

  always_comb begin
    bmask_st = 4'b0000;
    wdata_st = i_rs2_data_m;
    case (funct3)
      3'b000: begin
        bmask_st = 4'b0001 << i_alu_data_m[1:0];
        wdata_st = {4{i_rs2_data_m[7:0]}};
      end
      3'b001: begin
        bmask_st = i_alu_data_m[1] ? 4'b1100 : 4'b0011;
        wdata_st = {2{i_rs2_data_m[15:0]}};
      end
      3'b010:  bmask_st = 4'b1111;
      default: bmask_st = 4'b0000;
    endcase
  end

  // Lane select and extension of the live read word; unsupported funct3 loads return 0.
  always_comb begin
    ld_half = i_alu_data_m[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    case (i_alu_data_m[1:0])
      2'd0:    ld_byte = i_dmem_rdata[7:0];
      2'd1:    ld_byte = i_dmem_rdata[15:8];
      2'd2:    ld_byte = i_dmem_rdata[23:16];
      default: ld_byte = i_dmem_rdata[31:24];
    endcase
    case (funct3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_ext = i_dmem_rdata;
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ld_d    = ld_q;
    req     = 1'b0;
    stall   = 1'b0;
    bus_err = 1'b0;
    ld_out  = 32'h0;
    case (state_q)
      IDLE: begin
        if (go) begin
          req = 1'b1;
          if (i_dmem_ack) begin
            ld_out = is_load ? ld_ext : 32'h0;
          end else begin
            stall   = 1'b1;
            state_d = BUSY;
            cnt_d   = '0;
            err_d   = 1'b0;
          end
        end
      end
      BUSY: begin
        req   = 1'b1;
        stall = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (i_dmem_ack) begin
          ld_d    = is_load ? ld_ext : 32'h0;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          ld_d    = 32'h0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        ld_out  = ld_q;
        bus_err = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ld_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ld_q    <= ld_d;
    end
  end

  // Gating with i_rst drops the request asynchronously, before the flops settle.
  assign o_dmem_req   = i_rst & req;
  assign o_stall_m    = i_rst & stall;
  assign o_dmem_we    = o_dmem_req & is_store;
  assign o_dmem_addr  = o_dmem_req ? {i_alu_data_m[31:2], 2'b00} : 32'h0;
  assign o_dmem_wdata = o_dmem_we ? wdata_st : 32'h0;
  assign o_dmem_bmask = !o_dmem_req ? 4'b0000 : (is_store ? bmask_st : 4'b1111);
  assign o_ld_data    = i_rst ? ld_out : 32'h0;
  assign o_bus_err    = i_rst & bus_err;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - scoreboard bench for mem_stage_lsu with directed vectors.
module tb_mem_stage_lsu;
  localparam int TO = 8;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_alu_data_m, i_rs2_data_m, i_instrM, i_dmem_rdata;
  logic        i_mem_wren_m, i_wb_sel_m, i_dmem_ack;
  logic        o_dmem_req, o_dmem_we, o_stall_m, o_bus_err, o_misalign;
  logic [31:0] o_dmem_addr, o_dmem_wdata, o_ld_data;
  logic [3:0]  o_dmem_bmask;

  mem_stage_lsu #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_alu_data_m(i_alu_data_m), .i_rs2_data_m(i_rs2_data_m), .i_instrM(i_instrM),
    .i_mem_wren_m(i_mem_wren_m), .i_wb_sel_m(i_wb_sel_m),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_bmask(o_dmem_bmask),
    .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
    .o_ld_data(o_ld_data), .o_stall_m(o_stall_m), .o_bus_err(o_bus_err),
    .o_misalign(o_misalign)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int          req_cyc;
    int          stall_cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    logic [31:0] ld;
    logic        err;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  // ack_at: cycle of the ack counted from the IDLE cycle (0 = zero-wait), -1 = never.
  function automatic exp_t mk(input int ack_at, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] bm,
                              input logic [31:0] ld, input logic err);
    exp_t e;
    e.req_cyc   = (ack_at < 0) ? TO + 1 : ack_at + 1;
    e.stall_cyc = (e.req_cyc == 1) ? 0 : e.req_cyc;
    e.we = we; e.addr = addr; e.wdata = wdata; e.bmask = bm; e.ld = ld; e.err = err;
    return e;
  endfunction

  task automatic bubble();
    i_instrM = 32'h0; i_alu_data_m = 32'h0; i_rs2_data_m = 32'h0;
    i_mem_wren_m = 1'b0; i_wb_sel_m = 1'b0; i_dmem_ack = 1'b0; i_dmem_rdata = 32'h0;
  endtask

  task automatic drive(input logic [2:0] f3, input logic st, input logic ld,
                       input logic [31:0] addr, input logic [31:0] rs2);
    i_instrM = {17'h0, f3, 12'h003};
    i_alu_data_m = addr; i_rs2_data_m = rs2;
    i_mem_wren_m = st; i_wb_sel_m = ld;
  endtask

  // Called just after a rising edge; holds the instruction through DONE, then one bubble.
  task automatic access(input logic [2:0] f3, input logic st, input logic ld,
                        input logic [31:0] addr, input logic [31:0] rs2,
                        input int ack_at, input logic [31:0] rdata, input exp_t e);
    int total;
    q.push_back(e);
    total = (ack_at == 0) ? 1 : ((ack_at > 0) ? ack_at + 2 : TO + 2);
    drive(f3, st, ld, addr, rs2);
    for (int c = 0; c < total; c++) begin
      i_dmem_ack   = (c == ack_at);
      i_dmem_rdata = (c == ack_at) ? rdata : 32'h5A5AA5A5;
      @(posedge i_clk); #1;
    end
    bubble();
    @(posedge i_clk); #1;
  endtask

  int   req_cnt = 0;
  int   stall_cnt = 0;
  logic prev_stall = 1'b0;
  logic cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_bm;

  always @(negedge i_clk) begin : monitor
    logic ev;
    exp_t e;
    if (!i_rst) begin
      req_cnt = 0; stall_cnt = 0; prev_stall = 1'b0;
    end else begin
      if (o_dmem_req) begin
        if (req_cnt == 0) begin
          cap_we = o_dmem_we; cap_addr = o_dmem_addr; cap_wdata = o_dmem_wdata; cap_bm = o_dmem_bmask;
        end
        req_cnt++;
      end
      if (o_stall_m) stall_cnt++;
      ev = (o_dmem_req && !o_stall_m) || (prev_stall && !o_stall_m && !o_dmem_req);
      if (ev) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got ld %h with no expected entry", o_ld_data);
        end else begin
          e = q.pop_front();
          chk("req_cycles", req_cnt, e.req_cyc);
          chk("stall_cycles", stall_cnt, e.stall_cyc);
          chk("we", {31'h0, cap_we}, {31'h0, e.we});
          chk("addr", cap_addr, e.addr);
          chk("wdata", cap_wdata, e.wdata);
          chk("bmask", {28'h0, cap_bm}, {28'h0, e.bmask});
          chk("ld_data", o_ld_data, e.ld);
          chk("bus_err", {31'h0, o_bus_err}, {31'h0, e.err});
        end
        req_cnt = 0; stall_cnt = 0;
      end else if (o_bus_err) begin
        checks++; errors++;
        $display("FAIL stray_bus_err: got 1 expected 0");
      end
      prev_stall = o_stall_m;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bubble();
    i_rst = 1'b1;
    #1 i_rst = 1'b0;
    drive(3'b010, 1'b0, 1'b1, 32'h100, 32'h0);
    i_dmem_ack = 1'b1; i_dmem_rdata = 32'hFFFFFFFF;
    #2;
    chk("rst_req", {31'h0, o_dmem_req}, 32'h0);
    chk("rst_stall", {31'h0, o_stall_m}, 32'h0);
    chk("rst_we", {31'h0, o_dmem_we}, 32'h0);
    chk("rst_addr", o_dmem_addr, 32'h0);
    chk("rst_wdata", o_dmem_wdata, 32'h0);
    chk("rst_bmask", {28'h0, o_dmem_bmask}, 32'h0);
    chk("rst_ld", o_ld_data, 32'h0);
    chk("rst_err", {31'h0, o_bus_err}, 32'h0);
    chk("rst_mis", {31'h0, o_misalign}, 32'h0);
    repeat (2) @(posedge i_clk);
    #1 bubble();
    i_rst = 1'b1;
    @(posedge i_clk); #1;

    // ack in IDLE without an access is ignored
    i_dmem_ack = 1'b1; i_dmem_rdata = 32'h12345678;
    #1;
    chk("idle_ack_req", {31'h0, o_dmem_req}, 32'h0);
    chk("idle_ack_ld", o_ld_data, 32'h0);
    @(posedge i_clk); #1 bubble();

    access(3'b010, 0, 1, 32'h100, 32'h0, 0, 32'hDEADBEEF, mk(0, 0, 32'h100, 32'h0, 4'hF, 32'hDEADBEEF, 0));
    access(3'b000, 0, 1, 32'h103, 32'h0, 3, 32'h80FF0000, mk(3, 0, 32'h100, 32'h0, 4'hF, 32'hFFFFFF80, 0));
    access(3'b100, 0, 1, 32'h103, 32'h0, 3, 32'h80FF0000, mk(3, 0, 32'h100, 32'h0, 4'hF, 32'h00000080, 0));
    access(3'b001, 1, 0, 32'h202, 32'h1234ABCD, 1, 32'h0, mk(1, 1, 32'h200, 32'hABCDABCD, 4'hC, 32'h0, 0));
    access(3'b000, 1, 0, 32'h101, 32'h0000005A, 0, 32'h0, mk(0, 1, 32'h100, 32'h5A5A5A5A, 4'h2, 32'h0, 0));
    access(3'b001, 0, 1, 32'h102, 32'h0, 2, 32'h80011234, mk(2, 0, 32'h100, 32'h0, 4'hF, 32'hFFFF8001, 0));
    access(3'b101, 0, 1, 32'h100, 32'h0, 1, 32'h8001F00D, mk(1, 0, 32'h100, 32'h0, 4'hF, 32'h0000F00D, 0));
    access(3'b010, 1, 1, 32'h300, 32'hCAFEF00D, 0, 32'h11111111, mk(0, 1, 32'h300, 32'hCAFEF00D, 4'hF, 32'h0, 0));
    access(3'b011, 0, 1, 32'h104, 32'h0, 0, 32'h77777777, mk(0, 0, 32'h104, 32'h0, 4'hF, 32'h0, 0));
    access(3'b010, 0, 1, 32'h104, 32'h0, -1, 32'h0, mk(-1, 0, 32'h104, 32'h0, 4'hF, 32'h0, 1));

    // reset on the 2nd BUSY cycle
    drive(3'b000, 1'b0, 1'b1, 32'h100, 32'h0);
    repeat (2) begin @(posedge i_clk); #1; end
    #2 i_rst = 1'b0;
    #1;
    chk("midrst_req", {31'h0, o_dmem_req}, 32'h0);
    chk("midrst_stall", {31'h0, o_stall_m}, 32'h0);
    @(posedge i_clk); #1 bubble();
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    chk("post_rst_req", {31'h0, o_dmem_req}, 32'h0);
    chk("post_rst_stall", {31'h0, o_stall_m}, 32'h0);
    access(3'b010, 0, 1, 32'h108, 32'h0, 1, 32'h0BADCAFE, mk(1, 0, 32'h108, 32'h0, 4'hF, 32'h0BADCAFE, 0));

`ifdef LSU_MISALIGN_TRAP_EN
    drive(3'b010, 1'b0, 1'b1, 32'h102, 32'h0);
    i_dmem_ack = 1'b0;
    #1;
    chk("mis_flag", {31'h0, o_misalign}, 32'h1);
    chk("mis_req", {31'h0, o_dmem_req}, 32'h0);
    chk("mis_stall", {31'h0, o_stall_m}, 32'h0);
    chk("mis_ld", o_ld_data, 32'h0);
    @(posedge i_clk); #1 bubble();
    @(posedge i_clk); #1;
`else
    drive(3'b010, 1'b0, 1'b1, 32'h102, 32'h0);
    #1;
    chk("nomis_flag", {31'h0, o_misalign}, 32'h0);
    bubble();
    access(3'b010, 0, 1, 32'h102, 32'h0, 0, 32'h11223344, mk(0, 0, 32'h100, 32'h0, 4'hF, 32'h11223344, 0));
`endif

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge i_clk);
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: got %0d pending results expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
